noc_credit_rx_port: RTL

//  Router-side local input port; receiving end of the PE flit/credit link.

---
 rtl/noc_credit_rx_port_pkg.sv | 22 ++
 rtl/noc_credit_rx_port_if.sv | 31 +++
 rtl/noc_credit_rx_port_flit_fifo.sv | 72 +++++++
 rtl/noc_credit_rx_port.sv | 56 +++++
 4 files changed

// File: rtl/noc_credit_rx_port_pkg.sv
// Shared constants and helpers for the router-side PE link port.
// Credit count and flit width must match the sending PE.
package noc_credit_rx_port_pkg;

  localparam int FLIT_W      = 20;
  localparam int NOC_CREDITS = 7;
  localparam int DEPTH       = NOC_CREDITS;
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = $clog2(DEPTH + 1);

  typedef logic [FLIT_W-1:0] flit_t;

  // DEPTH is not a power of two, so the wrap point is compared explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = ptr + 1'b1;
    end
  endfunction

endpackage

// File: rtl/noc_credit_rx_port_if.sv
// PE-to-router flit/credit link plus the switch-facing valid/ready handshake.
// slave is the port's view; master is the view of the PE/switch environment.
interface noc_credit_rx_port_if;
  import noc_credit_rx_port_pkg::*;

  flit_t in_flit;
  logic  in_valid;
  flit_t out_flit;
  logic  out_valid;
  logic  out_ready;
  logic  credit_out;

  modport slave (
    input  in_flit,
    input  in_valid,
    input  out_ready,
    output out_flit,
    output out_valid,
    output credit_out
  );

  modport master (
    output in_flit,
    output in_valid,
    output out_ready,
    input  out_flit,
    input  out_valid,
    input  credit_out
  );

endinterface

// File: rtl/noc_credit_rx_port_flit_fifo.sv
// Synchronous first-word-fall-through flit FIFO with non-power-of-two depth.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module noc_credit_rx_port_flit_fifo
  import noc_credit_rx_port_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  flit_t            wr_data,
  output flit_t            rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy
);

  flit_t            mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign occupancy = count_r;

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Flit storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Head flit, forced to zero while empty
  always_comb begin
    rd_data = {FLIT_W{1'b0}};
    if (empty) begin
      rd_data = {FLIT_W{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/noc_credit_rx_port.sv
// Router local input port: buffers PE flits, hands them to the switch and
// returns one registered credit pulse per flit drained.
module noc_credit_rx_port
  import noc_credit_rx_port_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  noc_credit_rx_port_if.slave link,
  output logic [CNT_W-1:0]    occupancy,
  output logic                overflow_err
);

  logic  full_s;
  logic  empty_s;
  logic  pop_s;
  logic  drop_s;
  logic  credit_r;
  logic  overflow_r;
  flit_t head_s;

  assign pop_s  = !empty_s && link.out_ready;
  assign drop_s = link.in_valid && full_s && !pop_s;

  noc_credit_rx_port_flit_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (link.in_valid),
    .pop       (pop_s),
    .wr_data   (link.in_flit),
    .rd_data   (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .occupancy (occupancy)
  );

  // Credit return and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      credit_r <= pop_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign link.out_flit   = head_s;
  assign link.out_valid  = !empty_s;
  assign link.credit_out = credit_r;
  assign overflow_err    = overflow_r;

endmodule
